// File: rtl/lane_pack_pkg.sv
// Shared types and the uniformity helper for the lane_pack_buffer slice.
// Optional bypass is controlled in the top by LANE_PACK_BUFFER_BYPASS_EN.
package lane_pack_pkg;

  localparam int PACKW = 20;

  typedef logic [2:0][2:1][4:4][1:0] hufu_t;
  typedef bit   [4:3][4:4][3:0][1:1] mvq_t;

  typedef struct packed {
    hufu_t hufu;
    mvq_t  mvq;
    logic  par;
    logic  uniform;
  } entry_t;

  // The producer replicates one scalar everywhere, so both fields must agree bit-for-bit.
  function automatic logic is_uniform(input logic [11:0] hufu, input logic [7:0] mvq);
    logic hufu_ok;
    logic mvq_ok;
    hufu_ok = (&hufu) | ~(|hufu);
    mvq_ok  = (&mvq) | ~(|mvq);
    return hufu_ok & mvq_ok & (hufu[0] == mvq[0]);
  endfunction

endpackage

// File: rtl/lane_pack_fifo_mem.sv
// DEPTH x entry_t storage with one synchronous write port and an async read port.
// Contents are intentionally not reset.
module lane_pack_fifo_mem
  import lane_pack_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [$clog2(DEPTH)-1:0]   waddr,
  input  entry_t                     wdata,
  input  logic [$clog2(DEPTH)-1:0]   raddr,
  output entry_t                     rdata
);

  entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/lane_pack_buffer.sv
// Uniformity-checking FIFO behind the pxvth lane-driver stage.
// Define LANE_PACK_BUFFER_BYPASS_EN for a zero-latency path through an empty buffer.
module lane_pack_buffer
  import lane_pack_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int ERRW  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [11:0]              in_hufu,
  input  logic [7:0]               in_mvq,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PACKW-1:0]         out_data,
  output logic                     out_par,
  output logic                     out_uniform,
  output logic [ERRW-1:0]          err_cnt,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  entry_t        in_entry;
  entry_t        rd_entry;
  entry_t        head;
  logic          accept;
  logic          mem_wr;
  logic          mem_rd;

  always_comb begin
    in_entry         = '0;
    in_entry.hufu    = in_hufu;
    in_entry.mvq     = in_mvq;
    in_entry.par     = ^{in_hufu, in_mvq};
    in_entry.uniform = is_uniform(in_hufu, in_mvq);
  end

  // Ready is a pure function of registered occupancy; a pop never frees a slot in the same cycle.
  assign in_ready = (level != FULL);
  assign accept   = in_valid && in_ready;
  assign mem_rd   = (level != '0) && out_ready;

`ifdef LANE_PACK_BUFFER_BYPASS_EN
  logic bypass;
  assign bypass = (level == '0) && in_valid && out_ready;
  assign mem_wr = accept && !bypass;

  always_comb begin
    head = '0;
    if (bypass) begin
      head = in_entry;
    end else if (level != '0) begin
      head = rd_entry;
    end
  end

  assign out_valid = (level != '0) || bypass;
`else
  assign mem_wr = accept;

  always_comb begin
    head = '0;
    if (level != '0) begin
      head = rd_entry;
    end
  end

  assign out_valid = (level != '0);
`endif

  assign out_data    = {head.hufu, head.mvq};
  assign out_par     = head.par;
  assign out_uniform = head.uniform;

  lane_pack_fifo_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (mem_wr),
    .waddr (wr_ptr),
    .wdata (in_entry),
    .raddr (rd_ptr),
    .rdata (rd_entry)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      err_cnt <= '0;
    end else begin
      if (mem_wr) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (mem_rd) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({mem_wr, mem_rd})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      // Counts every accepted beat, including ones that take the bypass path.
      if (accept && !in_entry.uniform && (err_cnt != '1)) begin
        err_cnt <= err_cnt + 1'b1;
      end
    end
  end

endmodule

// File: doc/lane_pack_buffer.md
Name: lane_pack_buffer

Overview:
- Downstream consumer of the pxvth lane-driver stage.
- Captures its two packed outputs each accepted beat: the 12-bit logic field shaped [2:0][2:1][4:4][1:0], and the 8-bit bit field shaped [4:3][4:4][3:0][1:1].
- Checks that each field is uniform (the producer replicates one scalar across every bit).
- Buffers the beats in a small FIFO with a valid/ready handshake toward the next stage.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, minimum 2.
- ERRW, 8, width of the saturating non-uniform-beat counter.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream beat present.
- in_ready  output  1  buffer can accept a beat.
- in_hufu  input  12  packed [2:0][2:1][4:4][1:0] field, flattened MSB-first.
- in_mvq  input  8  packed [4:3][4:4][3:0][1:1] field, flattened MSB-first.
- out_valid  output  1  head entry available.
- out_ready  input  1  downstream accepts the head entry.
- out_data  output  20  head entry, laid out as {hufu[11:0], mvq[7:0]}.
- out_par  output  1  reduction XOR of out_data.
- out_uniform  output  1  head entry passed the uniformity check.
- err_cnt  output  ERRW  saturating count of accepted non-uniform beats.
- level  output  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (async assert; release synchronised by the flop clock):
  - wr_ptr, rd_ptr, level and err_cnt go to 0.
  - out_valid=0 and in_ready=1.
  - out_data, out_par and out_uniform go to 0; storage RAM is not reset.
- Push: occurs when in_valid && in_ready. Pop: occurs when out_valid && out_ready.
- in_ready = (level != DEPTH). It is registered-equivalent and depends only on state, never combinationally on out_ready.
- out_valid = (level != 0). out_data, out_par and out_uniform are read from the entry at rd_ptr.
- Uniform check, per field:
  - The field is uniform when it is all-0 or all-1.
  - A beat is uniform when both fields are uniform AND hufu[0] == mvq[0].
  - This bit is stored with the entry.
- err_cnt:
  - Increments on every push of a non-uniform beat.
  - Saturates at 2^ERRW-1 and never wraps.
- out_par is stored at push time, not recomputed at read.
- Pointers are log2(DEPTH) bits wide and wrap modulo DEPTH.
- level rules:
  - Push only: level+1.
  - Pop only: level-1.
  - Push and pop together: level unchanged, both pointers advance.
- Full (level==DEPTH):
  - in_ready=0.
  - A same-cycle pop does NOT allow a same-cycle push (no combinational ready path).
- Empty (level==0):
  - out_valid=0 and out_ready is ignored.
  - A push appears at the output on the next cycle (latency 1).
- Upstream holds in_hufu/in_mvq stable while in_valid && !in_ready. Bench assertion.
- Reset mid-operation drops all queued entries immediately; entries are never replayed.
- Ordering is strict FIFO. No entry is ever dropped or duplicated.

Optional Feature:
- Macro: LANE_PACK_BUFFER_BYPASS_EN.
- Defined:
  - When level==0, in_valid=1 and out_ready=1, the beat passes combinationally to out_data/out_par/out_uniform with out_valid=1.
  - The beat is not written; pointers and level are unchanged.
  - err_cnt still updates for that beat.
  - Latency is 0 in this case only.
- Undefined: minimum latency is 1 cycle; no input-to-output combinational path exists.

Decomposition:
- Package lane_pack_pkg holds:
  - typedef hufu_t: logic [2:0][2:1][4:4][1:0].
  - typedef mvq_t: bit [4:3][4:4][3:0][1:1].
  - typedef entry_t: struct packed {hufu_t hufu; mvq_t mvq; logic par; logic uniform;}.
  - Constant PACKW = 20.
  - Function is_uniform().
- One sub-module, lane_pack_fifo_mem: DEPTH x entry_t register array with write port and async read port.
- Control, check and counter logic stays in the top.

Test Plan:
- Reset, then push hufu=12'hFFF, mvq=8'hFF -> next cycle out_valid=1, out_data=20'hFFFFF, out_uniform=1, out_par=0, err_cnt=0, level=1.
- Push 5 beats with out_ready=0, DEPTH=4:
  - in_ready drops after the 4th push and level=4.
  - The 5th beat is held.
  - Pop one -> in_ready=1 on the following cycle; order is preserved.
- Push hufu=12'h001, mvq=8'h00 -> out_uniform=0, err_cnt=1. Push hufu=12'h000, mvq=8'hFF -> err_cnt=2 (cross-field mismatch).
- Continuous push/pop at level=2 for 10 cycles -> level stays 2, pointers wrap, and output matches input delayed by 2 beats.
- Drive 260 non-uniform beats with ERRW=8 -> err_cnt saturates at 255.
- Assert rst with level=3 -> out_valid=0, level=0 and in_ready=1 immediately. Next push is the next output.
- With LANE_PACK_BUFFER_BYPASS_EN, empty buffer, in_valid=out_ready=1, beat 20'h00000 -> out_valid=1 in the same cycle and level stays 0.
